// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter.
//   estado_t   : converter FSM states
//   MAX_VALOR  : largest value that fits in four BCD digits
//   DIGITO_ERR : digit pattern shown when the input exceeds MAX_VALOR
//   AJUSTE     : amount added to a nibble before the shift
//   UMBRAL     : threshold at or above which a nibble is adjusted
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DESPLAZA,
    FIN
  } estado_t;

  localparam int unsigned MAX_VALOR  = 9999;
  localparam logic [3:0]  DIGITO_ERR = 4'hF;
  localparam logic [3:0]  AJUSTE     = 4'd3;
  localparam logic [3:0]  UMBRAL     = 4'd5;

endpackage

// File: rtl/module_bin_bcd_ajuste.sv
// Add-3 correction for a single BCD nibble, applied before each shift.
//   din  : current BCD nibble (0..9)
//   dout : din + 3 when din >= 5, otherwise din
module module_ajuste_bcd
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // A nibble of 5..9 would exceed 9 after doubling; +3 makes the carry land in
  // the next digit. Inputs 10..15 never occur, so 4-bit arithmetic suffices.
  assign dout = (din >= UMBRAL) ? (din + AJUSTE) : din;

endmodule

// File: rtl/module_bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one shift per clock).
//   clk, rst   : clock, asynchronous active-high reset
//   inicio     : start request, only honoured while idle
//   binario    : unsigned value, captured on the accepting edge
//   unidades/decenas/centenas/millares : BCD digits of the last result
//   listo      : digit outputs hold a completed result
//   ocupado    : conversion in progress
//   desborde   : last completed result was above 9999 (digits show F)
module module_bin_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inicio,
  input  logic [BIN_WIDTH-1:0] binario,
  output logic [3:0]           unidades,
  output logic [3:0]           decenas,
  output logic [3:0]           centenas,
  output logic [3:0]           millares,
  output logic                 listo,
  output logic                 ocupado,
  output logic                 desborde
);

  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int RW = 16 + BIN_WIDTH;

  estado_t         estado_q, estado_d;
  logic [RW-1:0]   trabajo_q, trabajo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [3:0]      uni_q, uni_d, dec_q, dec_d, cen_q, cen_d, mil_q, mil_d;
  logic            listo_q, listo_d;
  logic            ocupado_q, ocupado_d;
  logic            desborde_q, desborde_d;

  logic [15:0]     bcd_ajustado;
  logic [RW-1:0]   trabajo_ajustado;

  // Working register layout: {millares, centenas, decenas, unidades, bin}.
  for (genvar i = 0; i < 4; i++) begin : g_ajuste
    module_ajuste_bcd u_ajuste (
      .din  (trabajo_q[BIN_WIDTH + 4*i +: 4]),
      .dout (bcd_ajustado[4*i +: 4])
    );
  end

  assign trabajo_ajustado = {bcd_ajustado, trabajo_q[BIN_WIDTH-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q   <= IDLE;
      trabajo_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      uni_q      <= '0;
      dec_q      <= '0;
      cen_q      <= '0;
      mil_q      <= '0;
      listo_q    <= 1'b0;
      ocupado_q  <= 1'b0;
      desborde_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      trabajo_q  <= trabajo_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      uni_q      <= uni_d;
      dec_q      <= dec_d;
      cen_q      <= cen_d;
      mil_q      <= mil_d;
      listo_q    <= listo_d;
      ocupado_q  <= ocupado_d;
      desborde_q <= desborde_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    trabajo_d  = trabajo_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    uni_d      = uni_q;
    dec_d      = dec_q;
    cen_d      = cen_q;
    mil_d      = mil_q;
    listo_d    = listo_q;
    ocupado_d  = ocupado_q;
    desborde_d = desborde_q;

    unique case (estado_q)
      IDLE: begin
        if (inicio) begin
          trabajo_d = {16'd0, binario};
          cnt_d     = CW'(BIN_WIDTH);
          // Narrower inputs cannot exceed 9999, so overflow is tied off.
          ovf_d     = (BIN_WIDTH >= 14) && (32'(binario) > MAX_VALOR);
          listo_d   = 1'b0;
          ocupado_d = 1'b1;
          estado_d  = DESPLAZA;
        end
      end
      DESPLAZA: begin
        trabajo_d = {trabajo_ajustado[RW-2:0], 1'b0};
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          estado_d = FIN;
        end
      end
      FIN: begin
        // The final shift is not followed by an adjust, so the nibbles are
        // already the finished BCD digits.
        if (ovf_q) begin
          uni_d      = DIGITO_ERR;
          dec_d      = DIGITO_ERR;
          cen_d      = DIGITO_ERR;
          mil_d      = DIGITO_ERR;
          desborde_d = 1'b1;
        end else begin
          uni_d      = trabajo_q[BIN_WIDTH      +: 4];
          dec_d      = trabajo_q[BIN_WIDTH + 4  +: 4];
          cen_d      = trabajo_q[BIN_WIDTH + 8  +: 4];
          mil_d      = trabajo_q[BIN_WIDTH + 12 +: 4];
          desborde_d = 1'b0;
        end
        listo_d   = 1'b1;
        ocupado_d = 1'b0;
        estado_d  = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  assign unidades = uni_q;
  assign decenas  = dec_q;
  assign centenas = cen_q;
  assign millares = mil_q;
  assign listo    = listo_q;
  assign ocupado  = ocupado_q;
  assign desborde = desborde_q;

endmodule

// File: doc/module_bin_bcd.md
Name: module_bin_bcd

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one shift per clock. It sits directly upstream of the 7-segment display driver. It supplies the four BCD digits (unidades/decenas/centenas/millares) and the level-valid flag listo that the driver gates its digits on. Values above 9999 are flagged and shown as an error pattern.

Parameters:
BIN_WIDTH, 14, width of binary input; legal range 4..14. 14 bits covers 0..16383.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
inicio  input  1  start request; sampled only in IDLE
binario  input  BIN_WIDTH  unsigned value to convert; sampled on the accepting edge only
unidades  output  4  BCD units digit
decenas  output  4  BCD tens digit
centenas  output  4  BCD hundreds digit
millares  output  4  BCD thousands digit
listo  output  1  level; high while digit outputs hold a completed result
ocupado  output  1  high while a conversion is in progress (DESPLAZA or FIN)
desborde  output  1  level; high when the last completed result had binario > 9999

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; all digits=4'd0; listo=0; ocupado=0; desborde=0.
  - Internal shift register and counter are cleared.
- FSM states: IDLE, DESPLAZA, FIN.
- IDLE, inicio=1 (accept edge E0):
  - Load binario into the low part of the working register {m,c,d,u,bin}; BCD part=0.
  - counter=BIN_WIDTH.
  - Latch ovf = (binario > 9999).
  - listo<=0, ocupado<=1, go to DESPLAZA.
- IDLE, inicio=0: stay; outputs hold.
- DESPLAZA, each edge:
  - Every BCD nibble >= 5 gets +3 (combinational); then the whole register shifts left by 1; counter decrements.
  - When counter reaches 1 on this edge, go to FIN. Exactly BIN_WIDTH shifts are performed (edges E1..E_BIN_WIDTH).
- FIN (edge E_BIN_WIDTH+1):
  - If ovf=0: digit outputs<=BCD nibbles, desborde<=0.
  - If ovf=1: all four digits<=4'hF, desborde<=1.
  - listo<=1, ocupado<=0, go to IDLE.
- Latency: listo is high after edge BIN_WIDTH+1 counted from the accept edge (15 edges for the default).
- Digit outputs change only in FIN or on reset. During a conversion they keep the previous result, but listo=0.
- inicio while ocupado=1 (DESPLAZA or FIN): ignored, not queued.
- inicio held high continuously: a new conversion is accepted on the first IDLE edge after FIN. listo is then high for exactly one cycle.
- binario changing after the accept edge: no effect on the running conversion.
- Reset mid-conversion: abort immediately; outputs go to reset values. The next accept starts a fresh conversion.
- If BIN_WIDTH < 14, ovf is constant 0.
- Counter width: $clog2(BIN_WIDTH+1). Working register width: 16+BIN_WIDTH.

Decomposition:
- Package bcd_pkg:
  - state enum estado_t {IDLE, DESPLAZA, FIN}
  - localparam MAX_VALOR=9999
  - localparam DIGITO_ERR=4'hF
  - localparam AJUSTE=4'd3, UMBRAL=4'd5
- Sub-module module_ajuste_bcd: combinational; 4-bit in, 4-bit out, out = in>=5 ? in+3 : in. Instantiated 4 times, one per nibble.

Test Plan:
- binario=0, pulse inicio -> after 15 edges listo=1; digits 0,0,0,0; desborde=0; ocupado high for exactly 15 cycles.
- binario=1234 -> millares=1, centenas=2, decenas=3, unidades=4; listo=1, desborde=0.
- binario=9999, then binario=10000 -> first result 9,9,9,9 with desborde=0; second result F,F,F,F with desborde=1.
- Converting 1234: pulse inicio with binario=5678 at cycle 5 of the conversion -> ignored; result 1234. A later inicio with 5678 in IDLE gives 5,6,7,8, and digits hold 1234 while listo=0.
- Reset asserted asynchronously at cycle 7 of a 4321 conversion -> immediate digits=0, listo=0, ocupado=0. A new inicio with 42 gives 0,0,4,2 after 15 edges.
- inicio held high with binario stepping 1,2,3 -> back-to-back conversions; listo high for exactly one cycle per result; results 1, 2, 3 in order.
